// File: rtl/chitchat_pkg.sv
// Shared definitions for the Chitchat framer family: lane constants,
// CRC parameters, the TX state encoding and the frame-length helper.
package chitchat_pkg;

  localparam logic [15:0] COMMA_WORD = 16'h50BC;
  localparam logic [1:0]  COMMA_K    = 2'b01;
  localparam logic [15:0] CRC_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC_POLY   = 16'h1021;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMMA,
    ST_HDR,
    ST_FCNT,
    ST_LBCK,
    ST_MASK,
    ST_DATA,
    ST_CRC
  } chitchat_state_e;

  // Comma, header, counter, loopback, mask, 2 words per channel, CRC.
  function automatic int frame_len(input int n_ch);
    return 6 + 2 * n_ch;
  endfunction

endpackage

// File: rtl/chitchat_crc16_d16.sv
// CRC-16-CCITT advanced by one 16-bit word per call, MSB first; shared by
// the TX framer and the RX checker.
module chitchat_crc16_d16
  import chitchat_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [15:0] d,
  output logic [15:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 15; i >= 0; i--) begin
      if (crc_out[15] ^ d[i]) begin
        crc_out = {crc_out[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        crc_out = {crc_out[14:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/chitchat_tx_multi.sv
// N-channel Chitchat transmit framer: latches per-channel words, snapshots
// them at each frame start and serialises a CRC-protected frame on a GTX lane.
module chitchat_tx_multi
  import chitchat_pkg::*;
#(
  parameter int         N_CH             = 2,
  parameter logic [3:0] PROTOCOL_VER     = 4'd2,
  parameter logic [2:0] TX_GATEWARE_TYPE = 3'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_transmit_en,
  input  logic [2:0]           tx_location,
  input  logic [N_CH-1:0]      tx_valid,
  input  logic [32*N_CH-1:0]   tx_data,
  input  logic [15:0]          tx_loopback_frame_counter,
  output logic [15:0]          gtx_d,
  output logic [1:0]           gtx_k,
  output logic                 tx_send,
  output logic [15:0]          local_frame_counter
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(2 * N_CH) : 1;
  // Last DATA slot sits one word before the CRC, which closes the frame.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(frame_len(N_CH) - 7);
  localparam logic [3:0]       NCH_M1   = 4'(N_CH - 1);

  chitchat_state_e     state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [15:0]         fcnt_q, fcnt_d;
  logic [15:0]         crc_q, crc_d, crc_next;
  logic [15:0]         lane_q, lane_d;
  logic [1:0]          lane_k_q, lane_k_d;
  logic                send_q, send_d;
  logic [32*N_CH-1:0]  hold_q, hold_d;
  logic [N_CH-1:0]     fresh_q, fresh_d;
  logic [15:0]         frame_q [2*N_CH];
  logic [15:0]         frame_d [2*N_CH];
  logic [N_CH-1:0]     mask_q, mask_d;
  logic [2:0]          loc_q, loc_d;
  logic [15:0]         lbck_q, lbck_d;

  assign gtx_d               = lane_q;
  assign gtx_k               = lane_k_q;
  assign tx_send             = send_q;
  assign local_frame_counter = fcnt_q;

  // A valid in the snapshot cycle refills fresh for the following frame.
  always_comb begin
    hold_d  = hold_q;
    fresh_d = (state_q == ST_COMMA) ? '0 : fresh_q;
    for (int c = 0; c < N_CH; c++) begin
      if (tx_valid[c]) begin
        hold_d[32*c +: 32] = tx_data[32*c +: 32];
        fresh_d[c]         = 1'b1;
      end
    end
  end

  always_comb begin
    frame_d = frame_q;
    mask_d  = mask_q;
    loc_d   = loc_q;
    lbck_d  = lbck_q;
    if (state_q == ST_COMMA) begin
      for (int i = 0; i < 2 * N_CH; i++) begin
        frame_d[i] = hold_q[16*i +: 16];
      end
      mask_d = fresh_q;
      loc_d  = tx_location;
      lbck_d = tx_loopback_frame_counter;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    fcnt_d   = fcnt_q;
    send_d   = 1'b0;
    lane_d   = COMMA_WORD;
    lane_k_d = 2'b00;
    unique case (state_q)
      ST_IDLE: begin
        lane_k_d = COMMA_K;
        if (tx_transmit_en) state_d = ST_COMMA;
      end
      ST_COMMA: begin
        lane_k_d = COMMA_K;
        send_d   = 1'b1;
        state_d  = ST_HDR;
      end
      ST_HDR: begin
        lane_d  = {PROTOCOL_VER, TX_GATEWARE_TYPE, loc_q, 2'b00, NCH_M1};
        state_d = ST_FCNT;
      end
      ST_FCNT: begin
        lane_d  = fcnt_q;
        state_d = ST_LBCK;
      end
      ST_LBCK: begin
        lane_d  = lbck_q;
        state_d = ST_MASK;
      end
      ST_MASK: begin
        lane_d  = 16'(mask_q);
        idx_d   = '0;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        lane_d = frame_q[idx_q];
        if (idx_q == LAST_IDX) state_d = ST_CRC;
        else                   idx_d   = idx_q + 1'b1;
      end
      ST_CRC: begin
        lane_d  = crc_q;
        fcnt_d  = fcnt_q + 16'd1;
        state_d = tx_transmit_en ? ST_COMMA : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  chitchat_crc16_d16 u_crc (
    .crc_in  (crc_q),
    .d       (lane_d),
    .crc_out (crc_next)
  );

  always_comb begin
    crc_d = crc_q;
    case (state_q)
      ST_IDLE, ST_COMMA:                          crc_d = CRC_INIT;
      ST_HDR, ST_FCNT, ST_LBCK, ST_MASK, ST_DATA: crc_d = crc_next;
      default:                                    crc_d = crc_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      fcnt_q   <= '0;
      crc_q    <= CRC_INIT;
      lane_q   <= COMMA_WORD;
      lane_k_q <= COMMA_K;
      send_q   <= 1'b0;
      hold_q   <= '0;
      fresh_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      fcnt_q   <= fcnt_d;
      crc_q    <= crc_d;
      lane_q   <= lane_d;
      lane_k_q <= lane_k_d;
      send_q   <= send_d;
      hold_q   <= hold_d;
      fresh_q  <= fresh_d;
    end
  end

  // Snapshot copies are fully rewritten every frame start, so no reset.
  always_ff @(posedge clk) begin
    frame_q <= frame_d;
    mask_q  <= mask_d;
    loc_q   <= loc_d;
    lbck_q  <= lbck_d;
  end

endmodule
